// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers: widths, the zero register
// specifier and the control bundle carried from ID into EX.
package pipe_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ALUOP_W  = 3;
    localparam int unsigned REG_ZERO = 0;

    typedef struct packed {
        logic               regWrite;
        logic               memRead;
        logic               memWrite;
        logic               memToReg;
        logic               aluSrc;
        logic [ALUOP_W-1:0] aluOp;
    } id_ex_ctrl_t;

    // Control bundle of an injected no-op: nothing is written and memory is untouched.
    function automatic id_ex_ctrl_t bubble_ctrl();
        return '0;
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard equation: the load in EX writes a register the instruction in ID reads.
module load_use_detect
    import pipe_pkg::*;
#(
    parameter int unsigned REG_W = 5
) (
    input  logic             ex_memRead,
    input  logic [REG_W-1:0] ex_rt,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_usesRt,
    output logic             hazard_c
);

    logic rt_nonzero_c;
    logic rs_match_c;
    logic rt_match_c;

    // $0 is hardwired, so a load targeting it can never create a dependency.
    always_comb begin
        rt_nonzero_c = (ex_rt != REG_W'(REG_ZERO));
        rs_match_c   = (ex_rt == id_rs);
        rt_match_c   = id_usesRt && (ex_rt == id_rt);
        hazard_c     = ex_memRead && rt_nonzero_c && (rs_match_c || rt_match_c);
    end

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use stall generation, flush bubbles and a
// saturating count of load-use stalls.
module id_ex_pipe
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W  = pipe_pkg::DATA_W,
    parameter int unsigned REG_W   = 5,
    parameter int unsigned ALUOP_W = pipe_pkg::ALUOP_W,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [REG_W-1:0]   id_rs,
    input  logic [REG_W-1:0]   id_rt,
    input  logic [REG_W-1:0]   id_rd,
    input  logic               id_usesRt,
    input  logic               id_regDst,
    input  logic               id_regWrite,
    input  logic               id_memRead,
    input  logic               id_memWrite,
    input  logic               id_memToReg,
    input  logic               id_aluSrc,
    input  logic [ALUOP_W-1:0] id_aluOp,
    input  logic [DATA_W-1:0]  id_readData1,
    input  logic [DATA_W-1:0]  id_readData2,
    input  logic [DATA_W-1:0]  id_imm,
    input  logic               flush,
    output logic [REG_W-1:0]   ex_rs,
    output logic [REG_W-1:0]   ex_rt,
    output logic [REG_W-1:0]   ex_rd,
    output logic               ex_regWrite,
    output logic               ex_memRead,
    output logic               ex_memWrite,
    output logic               ex_memToReg,
    output logic               ex_aluSrc,
    output logic [ALUOP_W-1:0] ex_aluOp,
    output logic [DATA_W-1:0]  ex_readData1,
    output logic [DATA_W-1:0]  ex_readData2,
    output logic [DATA_W-1:0]  ex_imm,
    output logic               pcWrite,
    output logic               ifidWrite,
    output logic [CNT_W-1:0]   stallCount
);

    localparam int unsigned CTRL_AW = pipe_pkg::ALUOP_W;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic {
        NORMAL  = 1'b0,
        BUBBLED = 1'b1
    } state_t;

    state_t      state_q;
    id_ex_ctrl_t ctrl_q;
    id_ex_ctrl_t ctrl_d_c;
    logic        hazard_c;
    logic        bubble_c;
    logic        count_en_c;
    logic [REG_W-1:0] dst_c;

    load_use_detect #(
        .REG_W (REG_W)
    ) u_load_use_detect (
        .ex_memRead (ctrl_q.memRead),
        .ex_rt      (ex_rt),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_usesRt  (id_usesRt),
        .hazard_c   (hazard_c)
    );

    // Flush wins over hazard: the redirected fetch must not be held, and no stall is counted.
    always_comb begin
        bubble_c   = hazard_c || flush;
        count_en_c = hazard_c && !flush && (stallCount != CNT_MAX);
        pcWrite    = !hazard_c || flush;
        ifidWrite  = !hazard_c || flush;
        dst_c      = id_regDst ? id_rd : id_rt;

        ctrl_d_c          = bubble_ctrl();
        ctrl_d_c.regWrite = id_regWrite;
        ctrl_d_c.memRead  = id_memRead;
        ctrl_d_c.memWrite = id_memWrite;
        ctrl_d_c.memToReg = id_memToReg;
        ctrl_d_c.aluSrc   = id_aluSrc;
        ctrl_d_c.aluOp    = CTRL_AW'(id_aluOp);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= NORMAL;
            ctrl_q       <= bubble_ctrl();
            ex_rs        <= '0;
            ex_rt        <= '0;
            ex_rd        <= '0;
            ex_readData1 <= '0;
            ex_readData2 <= '0;
            ex_imm       <= '0;
            stallCount   <= '0;
        end else begin
            if (bubble_c) begin
                state_q      <= BUBBLED;
                ctrl_q       <= bubble_ctrl();
                ex_rs        <= '0;
                ex_rt        <= '0;
                ex_rd        <= '0;
                ex_readData1 <= '0;
                ex_readData2 <= '0;
                ex_imm       <= '0;
            end else begin
                state_q      <= NORMAL;
                ctrl_q       <= ctrl_d_c;
                ex_rs        <= id_rs;
                ex_rt        <= id_rt;
                ex_rd        <= dst_c;
                ex_readData1 <= id_readData1;
                ex_readData2 <= id_readData2;
                ex_imm       <= id_imm;
            end
            if (count_en_c) begin
                stallCount <= stallCount + CNT_W'(1);
            end
        end
    end

    // A bubble clears memRead, so the same EX slot can never stall twice in a row.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(state_q == BUBBLED && hazard_c))
                else $error("load-use hazard asserted in the cycle after a bubble");
        end
    end

    assign ex_regWrite = ctrl_q.regWrite;
    assign ex_memRead  = ctrl_q.memRead;
    assign ex_memWrite = ctrl_q.memWrite;
    assign ex_memToReg = ctrl_q.memToReg;
    assign ex_aluSrc   = ctrl_q.aluSrc;
    assign ex_aluOp    = ALUOP_W'(ctrl_q.aluOp);

endmodule

// File: tb/tb_id_ex_pipe.sv
// Directed bench for id_ex_pipe: capture, load-use stalls, flush priority, reset and counter saturation.
module tb_id_ex_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic        id_usesRt, id_regDst, id_regWrite, id_memRead, id_memWrite, id_memToReg, id_aluSrc;
    logic [2:0]  id_aluOp;
    logic [31:0] id_readData1, id_readData2, id_imm;
    logic        flush;

    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic        ex_regWrite, ex_memRead, ex_memWrite, ex_memToReg, ex_aluSrc;
    logic [2:0]  ex_aluOp;
    logic [31:0] ex_readData1, ex_readData2, ex_imm;
    logic        pcWrite, ifidWrite;
    logic [15:0] stallCount;

    logic [4:0]  s_rs, s_rt, s_rd;
    logic        s_regWrite, s_memRead, s_memWrite, s_memToReg, s_aluSrc;
    logic [2:0]  s_aluOp;
    logic [31:0] s_readData1, s_readData2, s_imm;
    logic        s_pcWrite, s_ifidWrite;
    logic [1:0]  s_stallCount;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    id_ex_pipe dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_usesRt(id_usesRt),
        .id_regDst(id_regDst), .id_regWrite(id_regWrite), .id_memRead(id_memRead),
        .id_memWrite(id_memWrite), .id_memToReg(id_memToReg), .id_aluSrc(id_aluSrc),
        .id_aluOp(id_aluOp), .id_readData1(id_readData1), .id_readData2(id_readData2),
        .id_imm(id_imm), .flush(flush),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_regWrite(ex_regWrite),
        .ex_memRead(ex_memRead), .ex_memWrite(ex_memWrite), .ex_memToReg(ex_memToReg),
        .ex_aluSrc(ex_aluSrc), .ex_aluOp(ex_aluOp), .ex_readData1(ex_readData1),
        .ex_readData2(ex_readData2), .ex_imm(ex_imm),
        .pcWrite(pcWrite), .ifidWrite(ifidWrite), .stallCount(stallCount)
    );

    id_ex_pipe #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_usesRt(id_usesRt),
        .id_regDst(id_regDst), .id_regWrite(id_regWrite), .id_memRead(id_memRead),
        .id_memWrite(id_memWrite), .id_memToReg(id_memToReg), .id_aluSrc(id_aluSrc),
        .id_aluOp(id_aluOp), .id_readData1(id_readData1), .id_readData2(id_readData2),
        .id_imm(id_imm), .flush(flush),
        .ex_rs(s_rs), .ex_rt(s_rt), .ex_rd(s_rd), .ex_regWrite(s_regWrite),
        .ex_memRead(s_memRead), .ex_memWrite(s_memWrite), .ex_memToReg(s_memToReg),
        .ex_aluSrc(s_aluSrc), .ex_aluOp(s_aluOp), .ex_readData1(s_readData1),
        .ex_readData2(s_readData2), .ex_imm(s_imm),
        .pcWrite(s_pcWrite), .ifidWrite(s_ifidWrite), .stallCount(s_stallCount)
    );

    // Clock one edge, then settle so registered outputs can be sampled.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one decoded instruction into ID; settles combinational outputs before returning.
    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic uses_rt, input logic reg_dst, input logic reg_write,
                         input logic mem_read, input logic [31:0] d1);
        id_rs = rs; id_rt = rt; id_rd = rd; id_usesRt = uses_rt; id_regDst = reg_dst;
        id_regWrite = reg_write; id_memRead = mem_read; id_memWrite = 1'b0;
        id_memToReg = mem_read; id_aluSrc = mem_read; id_aluOp = 3'd2;
        id_readData1 = d1; id_readData2 = 32'h1111_2222; id_imm = 32'h0000_0010;
        #1;
    endtask

    task automatic drive_lw(input logic [4:0] rs, input logic [4:0] rt);
        drive(rs, rt, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
    endtask

    task automatic drive_add(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        drive(rs, rt, rd, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0;
        drive($urandom_range(31), $urandom_range(31), $urandom_range(31), 1'b1, 1'b1, 1'b1, 1'b1, $urandom);
        repeat (3) step();
        checks++;
        if ({ex_rs, ex_rt, ex_rd, ex_regWrite, ex_memRead, ex_memWrite, ex_memToReg, ex_aluSrc, ex_aluOp} !== '0) begin
            failures++; $display("FAIL reset_ctrl: got rs=%0d rt=%0d rd=%0d rw=%b mr=%b, expected all zero",
                                 ex_rs, ex_rt, ex_rd, ex_regWrite, ex_memRead);
        end
        checks++;
        if ({ex_readData1, ex_readData2, ex_imm} !== '0) begin
            failures++; $display("FAIL reset_data: got %h %h %h, expected zero", ex_readData1, ex_readData2, ex_imm);
        end
        checks++;
        if (stallCount !== 16'd0 || pcWrite !== 1'b1 || ifidWrite !== 1'b1) begin
            failures++; $display("FAIL reset_stall: got cnt=%0d pcWrite=%b ifidWrite=%b, expected 0 1 1",
                                 stallCount, pcWrite, ifidWrite);
        end
        drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_dest_select();
        drive(5'd3, 5'd9, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF);
        step();
        checks++;
        if (ex_rd !== 5'd5 || ex_rs !== 5'd3 || ex_rt !== 5'd9 || ex_regWrite !== 1'b1) begin
            failures++; $display("FAIL dest_rd: got rd=%0d rs=%0d rt=%0d rw=%b, expected 5 3 9 1",
                                 ex_rd, ex_rs, ex_rt, ex_regWrite);
        end
        checks++;
        if (ex_readData1 !== 32'hDEAD_BEEF || ex_readData2 !== 32'h1111_2222 || ex_imm !== 32'h10 || ex_aluOp !== 3'd2) begin
            failures++; $display("FAIL dest_data: got d1=%h d2=%h imm=%h op=%0d, expected deadbeef 11112222 10 2",
                                 ex_readData1, ex_readData2, ex_imm, ex_aluOp);
        end
        drive(5'd3, 5'd9, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        step();
        checks++;
        if (ex_rd !== 5'd9) begin
            failures++; $display("FAIL dest_rt: got rd=%0d, expected 9", ex_rd);
        end
    endtask

    task automatic test_load_use();
        drive_lw(5'd1, 5'd8);
        step();
        drive_add(5'd8, 5'd2, 5'd10);
        checks++;
        if (pcWrite !== 1'b0 || ifidWrite !== 1'b0) begin
            failures++; $display("FAIL lu_stall: got pcWrite=%b ifidWrite=%b, expected 0 0", pcWrite, ifidWrite);
        end
        step();
        checks++;
        if (ex_regWrite !== 1'b0 || ex_rd !== 5'd0 || ex_memRead !== 1'b0 || stallCount !== 16'd1) begin
            failures++; $display("FAIL lu_bubble: got rw=%b rd=%0d mr=%b cnt=%0d, expected 0 0 0 1",
                                 ex_regWrite, ex_rd, ex_memRead, stallCount);
        end
        checks++;
        if (pcWrite !== 1'b1) begin
            failures++; $display("FAIL lu_release: got pcWrite=%b, expected 1", pcWrite);
        end
        step();
        checks++;
        if (ex_rd !== 5'd10 || ex_rs !== 5'd8 || ex_regWrite !== 1'b1 || stallCount !== 16'd1) begin
            failures++; $display("FAIL lu_capture: got rd=%0d rs=%0d rw=%b cnt=%0d, expected 10 8 1 1",
                                 ex_rd, ex_rs, ex_regWrite, stallCount);
        end
    endtask

    task automatic test_back_to_back();
        drive_lw(5'd1, 5'd8);
        step();
        drive_lw(5'd8, 5'd9);
        step();
        drive_lw(5'd8, 5'd9);
        step();
        drive_add(5'd9, 5'd4, 5'd11);
        checks++;
        if (pcWrite !== 1'b0 || ex_rt !== 5'd9 || ex_memRead !== 1'b1) begin
            failures++; $display("FAIL b2b_second: got pcWrite=%b rt=%0d mr=%b, expected 0 9 1",
                                 pcWrite, ex_rt, ex_memRead);
        end
        step();
        step();
        checks++;
        if (ex_rd !== 5'd11 || stallCount !== 16'd3) begin
            failures++; $display("FAIL b2b_count: got rd=%0d cnt=%0d, expected 11 3", ex_rd, stallCount);
        end
    endtask

    task automatic test_no_false_stall();
        drive_lw(5'd1, 5'd0);
        step();
        drive_add(5'd0, 5'd0, 5'd12);
        checks++;
        if (pcWrite !== 1'b1 || ifidWrite !== 1'b1) begin
            failures++; $display("FAIL zero_reg: got pcWrite=%b ifidWrite=%b, expected 1 1", pcWrite, ifidWrite);
        end
        drive_lw(5'd1, 5'd8);
        step();
        drive(5'd3, 5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        checks++;
        if (pcWrite !== 1'b1) begin
            failures++; $display("FAIL itype_rt: got pcWrite=%b, expected 1", pcWrite);
        end
        step();
        checks++;
        if (ex_rt !== 5'd8 || ex_regWrite !== 1'b1 || stallCount !== 16'd3) begin
            failures++; $display("FAIL itype_capture: got rt=%0d rw=%b cnt=%0d, expected 8 1 3",
                                 ex_rt, ex_regWrite, stallCount);
        end
    endtask

    task automatic test_flush_hazard();
        drive_lw(5'd1, 5'd8);
        step();
        drive_add(5'd8, 5'd2, 5'd10);
        flush = 1'b1;
        #1;
        checks++;
        if (pcWrite !== 1'b1 || ifidWrite !== 1'b1) begin
            failures++; $display("FAIL flush_pc: got pcWrite=%b ifidWrite=%b, expected 1 1", pcWrite, ifidWrite);
        end
        step();
        flush = 1'b0;
        checks++;
        if (ex_regWrite !== 1'b0 || ex_rd !== 5'd0 || ex_memRead !== 1'b0 || stallCount !== 16'd3) begin
            failures++; $display("FAIL flush_bubble: got rw=%b rd=%0d mr=%b cnt=%0d, expected 0 0 0 3",
                                 ex_regWrite, ex_rd, ex_memRead, stallCount);
        end
        drive_add(5'd4, 5'd5, 5'd6);
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++;
        if (ex_regWrite !== 1'b0 || ex_rs !== 5'd0 || ex_readData2 !== 32'h0) begin
            failures++; $display("FAIL flush_plain: got rw=%b rs=%0d d2=%h, expected 0 0 0",
                                 ex_regWrite, ex_rs, ex_readData2);
        end
    endtask

    task automatic test_reset_mid_stall();
        drive_lw(5'd1, 5'd8);
        step();
        drive_add(5'd8, 5'd2, 5'd10);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (ex_memRead !== 1'b0 || pcWrite !== 1'b1 || stallCount !== 16'd0) begin
            failures++; $display("FAIL rst_mid: got mr=%b pcWrite=%b cnt=%0d, expected 0 1 0",
                                 ex_memRead, pcWrite, stallCount);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++;
        if (ex_rd !== 5'd10 || ex_regWrite !== 1'b1 || stallCount !== 16'd0) begin
            failures++; $display("FAIL rst_restart: got rd=%0d rw=%b cnt=%0d, expected 10 1 0",
                                 ex_rd, ex_regWrite, stallCount);
        end
    endtask

    task automatic test_saturation();
        logic [1:0]  exp_small;
        logic [15:0] exp_big;
        for (int i = 0; i < 5; i++) begin
            drive_lw(5'd1, 5'd8);
            step();
            drive_add(5'd8, 5'd2, 5'd10);
            step();
            step();
            exp_small = (i >= 2) ? 2'd3 : 2'(i + 1);
            exp_big   = 16'(i + 1);
            checks++;
            if (s_stallCount !== exp_small || stallCount !== exp_big) begin
                failures++; $display("FAIL sat_%0d: got small=%0d big=%0d, expected %0d %0d",
                                     i, s_stallCount, stallCount, exp_small, exp_big);
            end
        end
    endtask

    initial begin
        test_reset();
        test_dest_select();
        test_load_use();
        test_back_to_back();
        test_no_false_stall();
        test_flush_hazard();
        test_reset_mid_stall();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
